// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and write-master state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_DATA,
    RESP,
    DONE,
    DRAIN
  } wr_mst_state_t;

endpackage

// File: rtl/axi_timeout_ctr.sv
// Response-wait counter: cleared on entry to the wait, counts enabled cycles,
// saturates instead of wrapping, flags the last allowed cycle.
module axi_timeout_ctr #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] CNT_MAX = '1;
      localparam logic [CW-1:0] LAST    = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt;

      // Count wait cycles; hold at all-ones so a long wait cannot alias back to zero.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expired = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/axi_lite_write_master.sv
// Single-outstanding AXI-Lite write master: one command in, concurrent AW/W,
// B collected (or timed out), one completion pulse out.
module axi_lite_write_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic              done_timeout
);

  wr_mst_state_t state;
  logic          aw_done;
  logic          w_done;
  logic          aw_ok;
  logic          w_ok;
  logic          ctr_clr;
  logic          ctr_en;
  logic          expired;

  // A channel counts as finished if it handshook earlier or is handshaking now.
  assign aw_ok   = aw_done | (AWVALID & AWREADY);
  assign w_ok    = w_done  | (WVALID  & WREADY);
  assign ctr_clr = (state == ADDR_DATA) && aw_ok && w_ok;
  assign ctr_en  = (state == RESP);

  axi_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  // Write FSM with all handshake and completion outputs registered.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      AWADDR       <= '0;
      AWVALID      <= 1'b0;
      WDATA        <= '0;
      WVALID       <= 1'b0;
      BREADY       <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      done_valid   <= 1'b0;
      done_resp    <= RESP_OKAY;
      done_timeout <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            AWADDR    <= cmd_addr;
            WDATA     <= cmd_data;
            AWVALID   <= 1'b1;
            WVALID    <= 1'b1;
            cmd_ready <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= ADDR_DATA;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ADDR_DATA: begin
          if (AWVALID && AWREADY) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (WVALID && WREADY) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            BREADY <= 1'b1;
            state  <= RESP;
          end
        end
        RESP: begin
          // A response arriving on the expiry cycle takes priority over the timeout.
          if (BVALID) begin
            done_resp    <= BRESP;
            done_timeout <= 1'b0;
            done_valid   <= 1'b1;
            BREADY       <= 1'b0;
            state        <= DONE;
          end else if (expired) begin
            done_resp    <= RESP_SLVERR;
            done_timeout <= 1'b1;
            done_valid   <= 1'b1;
            state        <= DRAIN;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        DRAIN: begin
          // Swallow the late response without reporting it.
          if (BVALID) begin
            BREADY    <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_write_master.sv
// Directed bench for axi_lite_write_master: table of single writes against a
// delay-programmable slave, plus back-to-back and reset-in-flight sequences.
module tb_axi_lite_write_master;

  logic        ACLK;
  logic        ARESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic        done_timeout;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  bresp;
    logic [1:0]  exp_resp;
    logic        exp_timeout;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  // back-to-back / reset sequence state
  int          n_acc;
  int          n_aw;
  int          n_dn;
  int          n_late;
  int          dn_cyc[2];
  logic [31:0] exp_aw[2];
  logic [31:0] exp_w[2];
  bit          got_resp;
  bit          acc3;

  axi_lite_write_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .AWADDR       (AWADDR),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .WDATA        (WDATA),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .BRESP        (BRESP),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .done_valid   (done_valid),
    .done_resp    (done_resp),
    .done_timeout (done_timeout)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One write through a slave that waits aw_dly/w_dly cycles of VALID before
  // READY and b_dly cycles after both handshakes before BVALID.
  // Called and returns at a falling edge; each iteration is one clock cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int acc_cyc  = 0;
    int aw_wait  = 0;
    int w_wait   = 0;
    int b_wait   = 0;
    int b_hs_cyc = 0;
    int n_done   = 0;
    bit accepted = 0;
    bit aw_seen  = 0;
    bit w_seen   = 0;
    bit aw_hs    = 0;
    bit w_hs     = 0;
    bit b_hs     = 0;
    bit in_drain = 0;
    bit aw_drop  = 0;
    bit w_drop   = 0;
    bit finished = 0;
    BRESP = v.bresp;
    for (int k = 0; k < 80; k++) begin
      if (b_hs && (k == b_hs_cyc + 2)) begin
        check($sformatf("v%0d_idle_cmd_ready", idx), 64'(cmd_ready), 64'(1));
        check($sformatf("v%0d_done_count", idx), 64'(n_done), 64'(1));
        finished = 1;
        break;
      end
      if (!accepted) begin
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_data  = v.data;
        if (cmd_ready) begin
          accepted = 1;
          acc_cyc  = k;
        end
      end else begin
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_data  = ~v.data;
      end
      if (done_valid) begin
        n_done++;
        if (n_done == 1) begin
          check($sformatf("v%0d_done_resp", idx), 64'(done_resp), 64'(v.exp_resp));
          check($sformatf("v%0d_done_timeout", idx), 64'(done_timeout), 64'(v.exp_timeout));
          check($sformatf("v%0d_latency", idx), 64'(k - acc_cyc), 64'(v.exp_lat));
          if (done_timeout) in_drain = 1;
        end
      end
      if (in_drain) begin
        check($sformatf("v%0d_drain_bready", idx), 64'(BREADY), 64'(1));
        check($sformatf("v%0d_drain_cmd_ready", idx), 64'(cmd_ready), 64'(0));
      end
      if (aw_hs && w_hs && !b_hs) begin
        BVALID = (b_wait >= v.b_dly);
        b_wait++;
        if (BVALID && BREADY) begin
          b_hs     = 1;
          b_hs_cyc = k;
          in_drain = 0;
        end
      end else begin
        BVALID = 1'b0;
      end
      if (!aw_hs) begin
        if (aw_seen) check($sformatf("v%0d_awvalid_hold", idx), 64'(AWVALID), 64'(1));
        if (AWVALID) begin
          if (!aw_seen) begin
            check($sformatf("v%0d_awaddr", idx), 64'(AWADDR), 64'(v.addr));
            aw_seen = 1;
          end
          AWREADY = (aw_wait >= v.aw_dly);
          aw_wait++;
          if (AWREADY) aw_hs = 1;
        end else begin
          AWREADY = 1'b0;
        end
      end else begin
        AWREADY = 1'b0;
        if (!aw_drop) begin
          check($sformatf("v%0d_awvalid_drop", idx), 64'(AWVALID), 64'(0));
          aw_drop = 1;
        end
      end
      if (!w_hs) begin
        if (w_seen) check($sformatf("v%0d_wvalid_hold", idx), 64'(WVALID), 64'(1));
        if (WVALID) begin
          if (!w_seen) begin
            check($sformatf("v%0d_wdata", idx), 64'(WDATA), 64'(v.data));
            w_seen = 1;
          end
          WREADY = (w_wait >= v.w_dly);
          w_wait++;
          if (WREADY) w_hs = 1;
        end else begin
          WREADY = 1'b0;
        end
      end else begin
        WREADY = 1'b0;
        if (!w_drop) begin
          check($sformatf("v%0d_wvalid_drop", idx), 64'(WVALID), 64'(0));
          w_drop = 1;
        end
      end
      @(negedge ACLK);
    end
    check($sformatf("v%0d_completed", idx), 64'(finished), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            addr           data           aw w  b   bresp  exp   to  lat
    vecs[0] = '{32'h0000_0003, 32'h0000_fb13, 0, 0, 0,  2'b00, 2'b00, 1'b0, 3};
    vecs[1] = '{32'h1000_0040, 32'hdead_beef, 0, 3, 0,  2'b00, 2'b00, 1'b0, 6};
    vecs[2] = '{32'h0000_0020, 32'h0000_0001, 2, 0, 1,  2'b10, 2'b10, 1'b0, 6};
    vecs[3] = '{32'h0000_0044, 32'ha5a5_5a5a, 1, 1, 0,  2'b01, 2'b01, 1'b0, 4};
    vecs[4] = '{32'hffff_fffc, 32'hffff_ffff, 0, 0, 3,  2'b11, 2'b11, 1'b0, 6};
    vecs[5] = '{32'h0000_0080, 32'h1234_5678, 0, 0, 7,  2'b01, 2'b01, 1'b0, 10};
    vecs[6] = '{32'h0000_0084, 32'h0000_0000, 0, 0, 12, 2'b01, 2'b10, 1'b1, 10};
    vecs[7] = '{32'h0000_0088, 32'hcafe_f00d, 2, 1, 8,  2'b00, 2'b10, 1'b1, 12};

    // reset held for two edges with a command waiting
    ARESETN   = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0055;
    cmd_data  = 32'h0000_0066;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BRESP     = 2'b00;
    @(posedge ACLK);
    @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awvalid", 64'(AWVALID), 64'(0));
    check("rst_wvalid", 64'(WVALID), 64'(0));
    check("rst_bready", 64'(BREADY), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_done_valid", 64'(done_valid), 64'(0));
    check("rst_done_resp", 64'(done_resp), 64'(0));
    check("rst_done_timeout", 64'(done_timeout), 64'(0));
    check("rst_awaddr", 64'(AWADDR), 64'(0));
    check("rst_wdata", 64'(WDATA), 64'(0));
    ARESETN   = 1'b1;
    cmd_valid = 1'b0;
    @(negedge ACLK);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // two queued commands back to back against a zero-wait slave
    exp_aw[0] = 32'h0000_0100;
    exp_aw[1] = 32'h0000_0200;
    exp_w[0]  = 32'h0000_1111;
    exp_w[1]  = 32'h0000_2222;
    n_acc     = 0;
    n_aw      = 0;
    n_dn      = 0;
    dn_cyc[0] = 0;
    dn_cyc[1] = 0;
    AWREADY   = 1'b1;
    WREADY    = 1'b1;
    BRESP     = 2'b11;
    cmd_valid = 1'b1;
    cmd_addr  = exp_aw[0];
    cmd_data  = exp_w[0];
    for (int k = 0; (k < 40) && (n_dn < 2); k++) begin
      if (n_acc == 1) begin
        cmd_addr = exp_aw[1];
        cmd_data = exp_w[1];
      end else if (n_acc == 2) begin
        cmd_valid = 1'b0;
      end
      BVALID = BREADY;
      if (cmd_valid && cmd_ready) n_acc++;
      if (AWVALID && (n_aw < 2)) begin
        check("b2b_awaddr", 64'(AWADDR), 64'(exp_aw[n_aw]));
        check("b2b_wdata", 64'(WDATA), 64'(exp_w[n_aw]));
        n_aw++;
      end
      if (done_valid && (n_dn < 2)) begin
        check("b2b_done_resp", 64'(done_resp), 64'(2'b11));
        check("b2b_done_timeout", 64'(done_timeout), 64'(0));
        dn_cyc[n_dn] = k;
        n_dn++;
      end
      @(negedge ACLK);
    end
    BVALID = 1'b0;
    check("b2b_done_count", 64'(n_dn), 64'(2));
    check("b2b_done_spacing", 64'(dn_cyc[1] - dn_cyc[0]), 64'(4));

    // third command: reset while waiting for its response
    got_resp  = 0;
    acc3      = 0;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0300;
    cmd_data  = 32'h0000_3333;
    for (int k = 0; k < 10; k++) begin
      if (acc3) cmd_valid = 1'b0;
      if (BREADY) begin
        got_resp = 1;
        break;
      end
      if (cmd_valid && cmd_ready) acc3 = 1;
      @(negedge ACLK);
    end
    check("rst_reach_resp", 64'(got_resp), 64'(1));
    cmd_valid = 1'b0;
    ARESETN   = 1'b0;
    @(negedge ACLK);
    check("mid_rst_awvalid", 64'(AWVALID), 64'(0));
    check("mid_rst_wvalid", 64'(WVALID), 64'(0));
    check("mid_rst_bready", 64'(BREADY), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("mid_rst_done_valid", 64'(done_valid), 64'(0));
    check("mid_rst_done_resp", 64'(done_resp), 64'(0));
    check("mid_rst_done_timeout", 64'(done_timeout), 64'(0));
    check("mid_rst_awaddr", 64'(AWADDR), 64'(0));
    check("mid_rst_wdata", 64'(WDATA), 64'(0));
    ARESETN = 1'b1;
    n_late  = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_valid) n_late++;
      @(negedge ACLK);
    end
    check("mid_rst_no_completion", 64'(n_late), 64'(0));
    check("mid_rst_idle_bready", 64'(BREADY), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
